// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: buffer state encoding,
// per-stage field widths and the bit layout of the full-width keep vector.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

    localparam int unsigned PIPE_CLR_W  = 64;
    localparam int unsigned PIPE_KEEP_W = 197;
    localparam int unsigned PIPE_CNT_W  = 32;

    // Per-stage widths: clr = IR and/or control word, keep = data fields carried forward.
    localparam int unsigned IFID_CLR_W  = 32;
    localparam int unsigned IFID_KEEP_W = 32;
    localparam int unsigned IDEX_CLR_W  = 64;
    localparam int unsigned IDEX_KEEP_W = 197;
    localparam int unsigned EXMEM_CLR_W  = 64;
    localparam int unsigned EXMEM_KEEP_W = 197;
    localparam int unsigned MEMWB_CLR_W  = 64;
    localparam int unsigned MEMWB_KEEP_W = 197;

    // Keep-vector layout, LSB first.
    localparam int unsigned KEEP_PC_OFF    = 0;
    localparam int unsigned KEEP_PC_W      = 32;
    localparam int unsigned KEEP_DST_OFF   = KEEP_PC_OFF + KEEP_PC_W;
    localparam int unsigned KEEP_DST_W     = 5;
    localparam int unsigned KEEP_R1P_OFF   = KEEP_DST_OFF + KEEP_DST_W;
    localparam int unsigned KEEP_R1P_W     = 5;
    localparam int unsigned KEEP_R2P_OFF   = KEEP_R1P_OFF + KEEP_R1P_W;
    localparam int unsigned KEEP_R2P_W     = 5;
    localparam int unsigned KEEP_D_OFF     = KEEP_R2P_OFF + KEEP_R2P_W;
    localparam int unsigned KEEP_D_W       = 20;
    localparam int unsigned KEEP_R1_OFF    = KEEP_D_OFF + KEEP_D_W;
    localparam int unsigned KEEP_R1_W      = 32;
    localparam int unsigned KEEP_R2_OFF    = KEEP_R1_OFF + KEEP_R1_W;
    localparam int unsigned KEEP_R2_W      = 32;
    localparam int unsigned KEEP_ALUR_OFF  = KEEP_R2_OFF + KEEP_R2_W;
    localparam int unsigned KEEP_ALUR_W    = 32;
    localparam int unsigned KEEP_EXT_OFF   = KEEP_ALUR_OFF + KEEP_ALUR_W;
    localparam int unsigned KEEP_EXT_W     = 32;
    localparam int unsigned KEEP_V0_OFF    = KEEP_EXT_OFF + KEEP_EXT_W;
    localparam int unsigned KEEP_V0_W      = 1;
    localparam int unsigned KEEP_A0_OFF    = KEEP_V0_OFF + KEEP_V0_W;
    localparam int unsigned KEEP_A0_W      = 1;

endpackage

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid.
// Optional perf counters (stall/bubble) are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CLR_W  = PIPE_CLR_W,
    parameter int unsigned KEEP_W = PIPE_KEEP_W
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = PIPE_CNT_W
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CLR_W-1:0]  in_clr_i,
    input  logic [KEEP_W-1:0] in_keep_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CLR_W-1:0]  out_clr_o,
    output logic [KEEP_W-1:0] out_keep_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    buf_state_e        state_q, state_d;
    logic              in_ready_q, out_valid_q;
    logic [CLR_W-1:0]  main_clr_q, main_clr_d, skid_clr_q, skid_clr_d;
    logic [KEEP_W-1:0] main_keep_q, main_keep_d, skid_keep_q, skid_keep_d;
    logic              push, pop;

    assign push = in_valid_i & in_ready_q;
    assign pop  = out_valid_q & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_clr_d  = main_clr_q;
        main_keep_d = main_keep_q;
        skid_clr_d  = skid_clr_q;
        skid_keep_d = skid_keep_q;
        if (flush_i) begin
            // Keep fields are deliberately left alone; only the bubble-defining fields clear.
            state_d    = StEmpty;
            main_clr_d = '0;
            skid_clr_d = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        main_clr_d  = in_clr_i;
                        main_keep_d = in_keep_i;
                        state_d     = StHalf;
                    end
                end
                StHalf: begin
                    if (push && !pop) begin
                        skid_clr_d  = in_clr_i;
                        skid_keep_d = in_keep_i;
                        state_d     = StFull;
                    end else if (push && pop) begin
                        main_clr_d  = in_clr_i;
                        main_keep_d = in_keep_i;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        main_clr_d  = skid_clr_q;
                        main_keep_d = skid_keep_q;
                        state_d     = StHalf;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_clr_q  <= '0;
            main_keep_q <= '0;
            skid_clr_q  <= '0;
            skid_keep_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != StFull);
            out_valid_q <= (state_d != StEmpty);
            main_clr_q  <= main_clr_d;
            main_keep_q <= main_keep_d;
            skid_clr_q  <= skid_clr_d;
            skid_keep_q <= skid_keep_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    // A drained main register still holds its last payload; mask it so a bubble reads zero.
    assign out_clr_o   = out_valid_q ? main_clr_q : '0;
    assign out_keep_o  = main_keep_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (in_valid_i && !in_ready_q && !flush_i) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (!out_valid_q) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: accepted inputs queue up, a negedge monitor
// checks every completed output handshake against the queue head.
module tb_pipe_stage_buf;

    localparam int unsigned CLR_W  = 64;
    localparam int unsigned KEEP_W = 197;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CLR_W-1:0]  in_clr, out_clr;
    logic [KEEP_W-1:0] in_keep, out_keep;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [CLR_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .CLR_W  (CLR_W),
        .KEEP_W (KEEP_W)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_clr_i    (in_clr),
        .in_keep_i   (in_keep),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_clr_o   (out_clr),
        .out_keep_o  (out_keep)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    function automatic logic [KEEP_W-1:0] keep_of(input logic [CLR_W-1:0] c);
        return {c, ~c, 69'(c)};
    endfunction

    task automatic chk(input string name, input logic [KEEP_W-1:0] act,
                       input logic [KEEP_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CLR_W-1:0] c);
        in_valid = v;
        in_clr   = c;
        in_keep  = keep_of(c);
    endtask

    // Monitor: pop/compare first, then drop or enqueue what the coming edge does to the input.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got clr %0h expected no output", out_clr);
            end else begin
                logic [CLR_W-1:0] e;
                e = exp_q.pop_front();
                chk("pop_clr", KEEP_W'(out_clr), KEEP_W'(e));
                chk("pop_keep", out_keep, keep_of(e));
            end
        end
        if (rst || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_clr);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        cyc(2);
        rst = 1'b0;
        chk("rst_out_valid", KEEP_W'(out_valid), 0);
        chk("rst_in_ready", KEEP_W'(in_ready), 1);
        chk("rst_out_clr", KEEP_W'(out_clr), 0);
        chk("rst_out_keep", out_keep, 0);
`ifdef PIPE_PERF_CNT_EN
        chk("rst_stall_cnt", KEEP_W'(stall_cnt), 0);
        chk("rst_bubble_cnt", KEEP_W'(bubble_cnt), 0);
`endif

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, CLR_W'(i));
            cyc(1);
            chk("stream_in_ready", KEEP_W'(in_ready), 1);
            chk("stream_out_clr", KEEP_W'(out_clr), KEEP_W'(i));
        end
        drive(1'b0, '0);
        cyc(2);
        chk("stream_drained", KEEP_W'(out_valid), 0);

        // Skid fill with downstream stalled, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 64'hA);
        cyc(1);
        chk("skid_in_ready_half", KEEP_W'(in_ready), 1);
        drive(1'b1, 64'hB);
        cyc(1);
        drive(1'b0, '0);
        chk("skid_in_ready_full", KEEP_W'(in_ready), 0);
        chk("skid_head", KEEP_W'(out_clr), 64'hA);
        cyc(3);
        chk("skid_hold_clr", KEEP_W'(out_clr), 64'hA);
        chk("skid_hold_valid", KEEP_W'(out_valid), 1);
        out_ready = 1'b1;
        cyc(1);
        chk("skid_in_ready_back", KEEP_W'(in_ready), 1);
        chk("skid_second", KEEP_W'(out_clr), 64'hB);
        cyc(1);
        chk("skid_empty_valid", KEEP_W'(out_valid), 0);
        chk("skid_empty_clr", KEEP_W'(out_clr), 0);

        // Flush while FULL, with a same-cycle push that must be dropped.
        out_ready = 1'b0;
        drive(1'b1, 64'hA);
        cyc(1);
        drive(1'b1, 64'hB);
        cyc(1);
        flush = 1'b1;
        drive(1'b1, 64'hC);
        cyc(1);
        flush = 1'b0;
        drive(1'b0, '0);
        chk("flush_out_valid", KEEP_W'(out_valid), 0);
        chk("flush_out_clr", KEEP_W'(out_clr), 0);
        chk("flush_in_ready", KEEP_W'(in_ready), 1);
        out_ready = 1'b1;
        cyc(3);
        chk("flush_no_ghost", KEEP_W'(out_valid), 0);

        // Reset beats flush and push in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 64'h5);
        cyc(1);
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 64'hD);
        cyc(1);
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, '0);
        chk("rstwin_out_valid", KEEP_W'(out_valid), 0);
        chk("rstwin_in_ready", KEEP_W'(in_ready), 1);
        chk("rstwin_out_clr", KEEP_W'(out_clr), 0);
        chk("rstwin_out_keep", out_keep, 0);
        out_ready = 1'b1;
        cyc(2);
        chk("rstwin_no_ghost", KEEP_W'(out_valid), 0);

`ifdef PIPE_PERF_CNT_EN
        out_ready = 1'b0;
        drive(1'b1, 64'hA);
        cyc(1);
        drive(1'b1, 64'hB);
        cyc(1);
        drive(1'b1, 64'hC);
        cyc(3);
        chk("perf_stall_3", KEEP_W'(stall_cnt), 3);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        drive(1'b0, '0);
        chk("perf_flush_keeps", KEEP_W'(stall_cnt), 3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("perf_rst_clears", KEEP_W'(stall_cnt), 0);
        chk("perf_rst_bubble", KEEP_W'(bubble_cnt), 0);
`endif

        cyc(1);
        chk("scoreboard_empty", KEEP_W'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Holds one pipeline-stage payload with a valid bit and a valid/ready handshake.
- Adds a 2-entry skid so upstream stalls are registered and do not ripple combinationally.
- Flush turns the stage into a bubble: control/instruction fields read as zero and valid drops.

Parameters:
- CLR_W, 64: width of the fields zeroed on flush and reset (IR + control signal word).
- KEEP_W, 197: width of the data fields (PC, dst, R1/R2 pos, D, R1, R2, ALU_R, ext, v0, a0); not cleared by flush.
- CNT_W, 32: perf counter width (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held entries and the same-cycle input.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  buffer can accept; registered, equals (state != FULL).
- in_clr  in  CLR_W  upstream clearable fields.
- in_keep  in  KEEP_W  upstream data fields.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_clr  out  CLR_W  head clearable fields; zero whenever out_valid=0.
- out_keep  out  KEEP_W  head data fields; held value when out_valid=0.
- stall_cnt  out  CNT_W  only with PIPE_PERF_CNT_EN.
- bubble_cnt  out  CNT_W  only with PIPE_PERF_CNT_EN.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous, active-high (rst). rst has priority over flush, and flush has priority over push/pop.
- Storage: main register (drives the outputs) plus skid register. The state is EMPTY, HALF or FULL.
- Events: push = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY:
  - push: load main -> HALF.
- HALF:
  - push & !pop: load skid -> FULL.
  - push & pop: load main from input, stay HALF.
  - pop & !push: -> EMPTY.
- FULL (in_ready=0):
  - pop: main <= skid -> HALF.
  - otherwise hold.
- Latency: 1 cycle from push to out_valid when the buffer is empty. Throughput is 1/cycle while out_ready=1.
- Ordering: strict FIFO. No entry is duplicated or lost except by flush.
- out_valid = (state != EMPTY), registered.
- Reset values: state=EMPTY, out_valid=0, in_ready=1, out_clr=0, out_keep=0, skid=0, counters=0.
- Flush:
  - Next state EMPTY; main and skid clr fields <= 0; keep fields hold.
  - Input asserted in the same cycle is dropped.
  - A pop in the same cycle is still seen by downstream (its handshake completed), but the buffer does not advance.
- Reset mid-transfer: all entries are lost and no partial state survives. in_ready is 1 on the first cycle after rst deasserts.
- The downstream stall case (FULL, out_ready=0) holds outputs stable indefinitely.
- The upstream must hold in_clr/in_keep stable while in_valid & !in_ready. The buffer does not depend on this for correctness.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with in_valid & !in_ready & !flush.
  - bubble_cnt increments each cycle with !out_valid & !rst.
  - Both counters wrap modulo 2^CNT_W and are cleared by rst only (not by flush).
- Undefined: counters and their ports are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - State encoding (ST_EMPTY=2'd0, ST_HALF=2'd1, ST_FULL=2'd2).
  - Per-stage CLR_W/KEEP_W localparams for IF/ID, ID/EX, EX/MEM, MEM/WB.
  - Field offset constants for packing/unpacking the keep vector.
- No sub-module. Main/skid storage and the state machine stay in one always block per register group. Counters are inline under the macro.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=1, out_clr=0, out_keep=0 (and counters=0 if enabled).
- Streaming: push clr=0x1, 0x2, 0x3 on consecutive cycles with out_ready=1 -> out_clr shows 0x1, 0x2, 0x3 one cycle later each, in_ready stays 1.
- Skid fill: out_ready=0, push 0xA then 0xB -> after 2 cycles in_ready=0, out_clr=0xA. Raise out_ready -> 0xA, then 0xB, in order. in_ready returns to 1 the cycle after the first pop.
- Flush in FULL: state FULL (0xA, 0xB), flush=1 with in_valid=1, clr=0xC -> next cycle out_valid=0, out_clr=0, in_ready=1; 0xC never appears.
- rst versus flush plus push in the same cycle: rst=1, flush=1, push 0xD -> reset values; rst wins.
- With PIPE_PERF_CNT_EN: 3 cycles in FULL with in_valid=1 -> stall_cnt=3. A flush does not clear stall_cnt; only rst does.
